// File: rtl/lcd_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// lcd_bus_arbiter_if
// Bundles the two requester write handshakes and the character-LCD pin bus
// that the arbiter drives.
//   req0/rs0/data0, req1/rs1/data1 : write requests from the two requesters
//   gnt0/gnt1   : one-cycle pulse, request accepted and latched
//   done0/done1 : one-cycle pulse, write fully executed on the LCD
//   busy        : arbiter is in the middle of a write
//   LCD_E/LCD_RS/LCD_RW/LCD_DATA : LCD pins
// Modports: slave = arbiter side, master = requester / pin-observer side.
// ---------------------------------------------------------------------------
interface lcd_bus_arbiter_if;
    logic       req0;
    logic       rs0;
    logic [7:0] data0;
    logic       gnt0;
    logic       done0;
    logic       req1;
    logic       rs1;
    logic [7:0] data1;
    logic       gnt1;
    logic       done1;
    logic       busy;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [7:0] LCD_DATA;

    modport slave (
        input  req0, rs0, data0, req1, rs1, data1,
        output gnt0, done0, gnt1, done1, busy,
        output LCD_E, LCD_RS, LCD_RW, LCD_DATA
    );

    modport master (
        output req0, rs0, data0, req1, rs1, data1,
        input  gnt0, done0, gnt1, done1, busy,
        input  LCD_E, LCD_RS, LCD_RW, LCD_DATA
    );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// ---------------------------------------------------------------------------
// lcd_bus_arbiter
// Round-robin arbiter sharing a character-LCD write bus between two
// requesters. Each granted write is played out as SETUP -> PULSE (LCD_E
// high) -> HOLD -> WAIT (controller execution time, long for clear/home)
// before the next request is accepted.
// Ports:
//   clk    : system clock, all state changes on its rising edge
//   resetn : synchronous, active-high reset
//   bus    : lcd_bus_arbiter_if.slave (requests, grants, done, LCD pins)
// ---------------------------------------------------------------------------
module lcd_bus_arbiter #(
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_PULSE = 4,
    parameter int unsigned T_HOLD  = 2,
    parameter int unsigned T_SHORT = 40,
    parameter int unsigned T_LONG  = 1600
) (
    input  logic               clk,
    input  logic               resetn,
    lcd_bus_arbiter_if.slave   bus
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_PULSE = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;

    // Terminal counts: each phase lasts T cycles, counter runs 0..T-1.
    localparam logic [15:0] SETUP_LAST = 16'(T_SETUP - 1);
    localparam logic [15:0] PULSE_LAST = 16'(T_PULSE - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(T_HOLD - 1);
    localparam logic [15:0] SHORT_LAST = 16'(T_SHORT - 1);
    localparam logic [15:0] LONG_LAST  = 16'(T_LONG - 1);

    logic [2:0]  state_reg;
    logic [15:0] count_reg;
    logic        last_reg;   // requester granted most recently
    logic        owner_reg;  // requester owning the write in flight
    logic        long_reg;   // write in flight is clear/home
    logic        gnt0_reg;
    logic        gnt1_reg;
    logic        done0_reg;
    logic        done1_reg;
    logic        busy_reg;
    logic        lcd_e_reg;
    logic        lcd_rs_reg;
    logic [7:0]  lcd_data_reg;

    logic        any_req;
    logic        pick1;
    logic        sel_rs;
    logic [7:0]  sel_data;
    logic        sel_long;
    logic [15:0] wait_last;

    // Requester 1 wins when alone, or when both ask and 0 was served last.
    always_comb begin
        any_req   = bus.req0 | bus.req1;
        pick1     = bus.req1 & (~bus.req0 | ~last_reg);
        sel_rs    = pick1 ? bus.rs1   : bus.rs0;
        sel_data  = pick1 ? bus.data1 : bus.data0;
        // Commands 0x01 (clear) and 0x02/0x03 (home) need the long wait.
        sel_long  = ~sel_rs && (sel_data[7:2] == 6'd0) && (sel_data != 8'd0);
        wait_last = long_reg ? LONG_LAST : SHORT_LAST;
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_reg    <= ST_IDLE;
            count_reg    <= 16'd0;
            last_reg     <= 1'b1;
            owner_reg    <= 1'b0;
            long_reg     <= 1'b0;
            gnt0_reg     <= 1'b0;
            gnt1_reg     <= 1'b0;
            done0_reg    <= 1'b0;
            done1_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            lcd_e_reg    <= 1'b0;
            lcd_rs_reg   <= 1'b0;
            lcd_data_reg <= 8'd0;
        end else begin
            gnt0_reg  <= 1'b0;
            gnt1_reg  <= 1'b0;
            done0_reg <= 1'b0;
            done1_reg <= 1'b0;
            count_reg <= count_reg + 16'd1;
            case (state_reg)
                ST_IDLE: begin
                    count_reg <= 16'd0;
                    if (any_req) begin
                        state_reg    <= ST_SETUP;
                        lcd_rs_reg   <= sel_rs;
                        lcd_data_reg <= sel_data;
                        long_reg     <= sel_long;
                        owner_reg    <= pick1;
                        last_reg     <= pick1;
                        gnt0_reg     <= ~pick1;
                        gnt1_reg     <= pick1;
                        busy_reg     <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (count_reg == SETUP_LAST) begin
                        state_reg <= ST_PULSE;
                        count_reg <= 16'd0;
                        lcd_e_reg <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (count_reg == PULSE_LAST) begin
                        state_reg <= ST_HOLD;
                        count_reg <= 16'd0;
                        lcd_e_reg <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (count_reg == HOLD_LAST) begin
                        state_reg <= ST_WAIT;
                        count_reg <= 16'd0;
                    end
                end
                ST_WAIT: begin
                    if (count_reg == wait_last) begin
                        state_reg <= ST_IDLE;
                        count_reg <= 16'd0;
                        busy_reg  <= 1'b0;
                        done0_reg <= ~owner_reg;
                        done1_reg <= owner_reg;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    count_reg <= 16'd0;
                    busy_reg  <= 1'b0;
                    lcd_e_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt0     = gnt0_reg;
    assign bus.gnt1     = gnt1_reg;
    assign bus.done0    = done0_reg;
    assign bus.done1    = done1_reg;
    assign bus.busy     = busy_reg;
    assign bus.LCD_E    = lcd_e_reg;
    assign bus.LCD_RS   = lcd_rs_reg;
    assign bus.LCD_RW   = 1'b0;  // write-only bus
    assign bus.LCD_DATA = lcd_data_reg;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lcd_bus_arbiter
// Self-checking bench for lcd_bus_arbiter: a table of single writes, hand
// sequences for alternation, reset during PULSE and a request raised while
// busy, then randomized requests checked against a round-robin / latency
// model computed from the timing rules.
// ---------------------------------------------------------------------------
module tb_lcd_bus_arbiter;

    localparam int T_SETUP = 2;
    localparam int T_PULSE = 4;
    localparam int T_HOLD  = 2;
    localparam int T_SHORT = 40;
    localparam int T_LONG  = 1600;

    logic clk = 1'b0;
    logic resetn = 1'b1;

    lcd_bus_arbiter_if bus_if();

    lcd_bus_arbiter #(
        .T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_HOLD(T_HOLD),
        .T_SHORT(T_SHORT), .T_LONG(T_LONG)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int model_last = 1;

    typedef struct {
        int         who;
        logic       rs;
        logic [7:0] data;
        int         exp_done;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference model: latency from the timing rules, arbitration by rotation.
    function automatic int model_latency(input logic rs, input logic [7:0] d);
        bit lng;
        lng = (rs == 1'b0) && (d == 8'h01 || d == 8'h02 || d == 8'h03);
        return T_SETUP + T_PULSE + T_HOLD + (lng ? T_LONG : T_SHORT);
    endfunction

    function automatic int model_pick(input bit r0, input bit r1);
        if (r0 && r1) return (model_last == 0) ? 1 : 0;
        return r0 ? 0 : 1;
    endfunction

    task automatic set_req(input int who, input bit v, input logic rs, input logic [7:0] d);
        if (who == 0) begin
            bus_if.req0 = v; bus_if.rs0 = rs; bus_if.data0 = d;
        end else begin
            bus_if.req1 = v; bus_if.rs1 = rs; bus_if.data1 = d;
        end
    endtask

    task automatic drop_req(input int who);
        if (who == 0) bus_if.req0 = 1'b0;
        else          bus_if.req1 = 1'b0;
    endtask

    task automatic raise_req(input int who);
        if (who == 0) bus_if.req0 = 1'b1;
        else          bus_if.req1 = 1'b1;
    endtask

    // Waits (bounded) for a grant; who=2 if both grants fire together.
    task automatic wait_grant(output int who, output int ticks);
        logic       prs;
        logic [7:0] pd;
        int         moved;
        prs = bus_if.LCD_RS;
        pd = bus_if.LCD_DATA;
        moved = 0;
        who = -1;
        ticks = 0;
        for (int i = 0; i < 3000 && who < 0; i++) begin
            tick();
            ticks++;
            if (bus_if.gnt0 === 1'b1 || bus_if.gnt1 === 1'b1)
                who = (bus_if.gnt0 === 1'b1 && bus_if.gnt1 === 1'b1) ? 2 : (bus_if.gnt1 === 1'b1 ? 1 : 0);
            else if (bus_if.LCD_RS !== prs || bus_if.LCD_DATA !== pd)
                moved++;
        end
        check("grant_seen", int'(who >= 0), 1);
        check("idle_bus_stable", moved, 0);
    endtask

    // Called in cycle 0 (grant visible). Follows the write to its done cycle.
    task automatic follow_write(input int who, input logic rs, input logic [7:0] d,
                                input int exp_lat, input bit keep, input int raise_at,
                                input string tag);
        int e_first, e_last, e_cnt, done_at;
        int busy_bad, bus_bad, rw_bad, stray_gnt, stray_done;
        bit exp_busy;
        e_first = -1; e_last = -1; e_cnt = 0; done_at = -1;
        busy_bad = 0; bus_bad = 0; rw_bad = 0; stray_gnt = 0; stray_done = 0;
        check({tag, "_rs_c0"}, int'(bus_if.LCD_RS), int'(rs));
        check({tag, "_data_c0"}, int'(bus_if.LCD_DATA), int'(d));
        check({tag, "_busy_c0"}, int'(bus_if.busy), 1);
        if (!keep) drop_req(who);
        for (int c = 1; c <= exp_lat + 10 && done_at < 0; c++) begin
            if (c - 1 == raise_at) raise_req(1 - who);
            tick();
            if (bus_if.LCD_E === 1'b1) begin
                if (e_first < 0) e_first = c;
                e_last = c;
                e_cnt++;
            end
            if ((who == 0 ? bus_if.done0 : bus_if.done1) === 1'b1) done_at = c;
            if ((who == 0 ? bus_if.done1 : bus_if.done0) === 1'b1) stray_done++;
            exp_busy = (done_at < 0);
            if (bus_if.busy !== exp_busy) busy_bad++;
            if (bus_if.LCD_RS !== rs || bus_if.LCD_DATA !== d) bus_bad++;
            if (bus_if.LCD_RW !== 1'b0) rw_bad++;
            if (bus_if.gnt0 !== 1'b0 || bus_if.gnt1 !== 1'b0) stray_gnt++;
        end
        check({tag, "_e_first"}, e_first, T_SETUP);
        check({tag, "_e_last"}, e_last, T_SETUP + T_PULSE - 1);
        check({tag, "_e_count"}, e_cnt, T_PULSE);
        check({tag, "_done_cycle"}, done_at, exp_lat);
        check({tag, "_busy"}, busy_bad, 0);
        check({tag, "_bus_stable"}, bus_bad, 0);
        check({tag, "_rw"}, rw_bad, 0);
        check({tag, "_stray_gnt"}, stray_gnt, 0);
        check({tag, "_stray_done"}, stray_done, 0);
    endtask

    initial begin
        int who, ticks, exp, quiet;
        bit r0, r1;
        logic rs0v, rs1v;
        logic [7:0] d0v, d1v;

        vecs[0] = '{0, 1'b1, 8'h41, 48};
        vecs[1] = '{1, 1'b0, 8'h01, 1608};
        vecs[2] = '{1, 1'b0, 8'h02, 1608};
        vecs[3] = '{1, 1'b0, 8'h00, 48};
        vecs[4] = '{1, 1'b0, 8'h38, 48};
        vecs[5] = '{0, 1'b0, 8'h03, 1608};
        vecs[6] = '{0, 1'b0, 8'h04, 48};
        vecs[7] = '{1, 1'b1, 8'h01, 48};

        set_req(0, 1'b0, 1'b0, 8'h00);
        set_req(1, 1'b0, 1'b0, 8'h00);

        // Reset state
        resetn = 1'b1;
        repeat (3) tick();
        check("rst_lcd_e", int'(bus_if.LCD_E), 0);
        check("rst_lcd_rs", int'(bus_if.LCD_RS), 0);
        check("rst_lcd_rw", int'(bus_if.LCD_RW), 0);
        check("rst_lcd_data", int'(bus_if.LCD_DATA), 0);
        check("rst_gnt", int'({bus_if.gnt0, bus_if.gnt1}), 0);
        check("rst_done", int'({bus_if.done0, bus_if.done1}), 0);
        check("rst_busy", int'(bus_if.busy), 0);
        resetn = 1'b0;
        tick();

        // Table of single-requester writes
        for (int i = 0; i < 8; i++) begin
            set_req(vecs[i].who, 1'b1, vecs[i].rs, vecs[i].data);
            wait_grant(who, ticks);
            check("vec_who", who, vecs[i].who);
            model_last = vecs[i].who;
            follow_write(vecs[i].who, vecs[i].rs, vecs[i].data, vecs[i].exp_done, 1'b0, -1, "vec");
            $display("vec %0d who=%0d rs=%0d data=%02h done_expected=%0d", i, vecs[i].who,
                     vecs[i].rs, vecs[i].data, vecs[i].exp_done);
            tick();
        end

        // Both requesters held high: strict alternation, 49 cycles apart
        set_req(0, 1'b1, 1'b1, 8'h30);
        set_req(1, 1'b1, 1'b1, 8'h31);
        for (int k = 0; k < 4; k++) begin
            exp = model_pick(1'b1, 1'b1);
            wait_grant(who, ticks);
            check("alt_who", who, exp);
            if (k > 0) check("alt_spacing", ticks, 1);
            model_last = exp;
            follow_write(exp, 1'b1, (exp == 0) ? 8'h30 : 8'h31, 48, 1'b1, -1, "alt");
            $display("alt grant %0d who=%0d", k, who);
        end
        drop_req(0);
        drop_req(1);
        tick();

        // Reset during PULSE abandons the write
        set_req(0, 1'b1, 1'b1, 8'h42);
        wait_grant(who, ticks);
        check("rstop_who", who, 0);
        drop_req(0);
        repeat (3) tick();
        check("rstop_e_cycle3", int'(bus_if.LCD_E), 1);
        resetn = 1'b1;
        tick();
        resetn = 1'b0;
        model_last = 1;
        check("rstop_e_after", int'(bus_if.LCD_E), 0);
        check("rstop_busy_after", int'(bus_if.busy), 0);
        quiet = 0;
        repeat (60) begin
            tick();
            if (bus_if.done0 !== 1'b0 || bus_if.done1 !== 1'b0 || bus_if.LCD_E !== 1'b0 ||
                bus_if.gnt0 !== 1'b0 || bus_if.gnt1 !== 1'b0) quiet++;
        end
        check("rstop_no_done", quiet, 0);
        set_req(0, 1'b1, 1'b1, 8'h43);
        set_req(1, 1'b1, 1'b1, 8'h44);
        exp = model_pick(1'b1, 1'b1);
        wait_grant(who, ticks);
        check("rstop_priority", who, exp);
        model_last = exp;
        follow_write(0, 1'b1, 8'h43, 48, 1'b0, -1, "rstop");
        drop_req(1);
        $display("reset-mid-pulse sequence who=%0d", who);
        tick();

        // Request raised while busy is served right after done
        set_req(1, 1'b0, 1'b1, 8'h55);
        set_req(0, 1'b1, 1'b1, 8'h46);
        wait_grant(who, ticks);
        check("late_first_who", who, 0);
        model_last = 0;
        follow_write(0, 1'b1, 8'h46, 48, 1'b0, 10, "late0");
        wait_grant(who, ticks);
        check("late_second_who", who, 1);
        check("late_second_spacing", ticks, 1);
        model_last = 1;
        follow_write(1, 1'b1, 8'h55, 48, 1'b0, -1, "late1");
        $display("late request sequence who=%0d ticks=%0d", who, ticks);
        tick();

        // Randomized requests against the model
        for (int n = 0; n < 25; n++) begin
            r0 = ($urandom_range(0, 1) == 1);
            r1 = !r0 || ($urandom_range(0, 1) == 1);
            rs0v = 1'($urandom_range(0, 1));
            rs1v = 1'($urandom_range(0, 1));
            d0v = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
            d1v = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
            set_req(0, r0, rs0v, d0v);
            set_req(1, r1, rs1v, d1v);
            exp = model_pick(r0, r1);
            wait_grant(who, ticks);
            check("rnd_who", who, exp);
            model_last = exp;
            follow_write(exp, (exp == 0) ? rs0v : rs1v, (exp == 0) ? d0v : d1v,
                         model_latency((exp == 0) ? rs0v : rs1v, (exp == 0) ? d0v : d1v),
                         1'b0, -1, "rnd");
            drop_req(0);
            drop_req(1);
            $display("rnd %0d req=%0d%0d who=%0d expected=%0d", n, r1, r0, who, exp);
            repeat ($urandom_range(1, 4)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
